// File: rtl/time_tmr_retry_pkg.sv
// rtl/time_tmr_retry_pkg.sv - shared types and sizing helpers for the retry issue stage
package time_tmr_retry_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        NEW   = 2'd1,
        SENT  = 2'd2,
        RETRY = 2'd3
    } entry_state_e;

    function automatic int retry_cnt_width(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/oldest_match_pick.sv
// rtl/oldest_match_pick.sv - oldest set bit of a circular match vector, counted from head
module oldest_match_pick #(
    parameter int N    = 16,
    parameter int IdxW = 4
) (
    input  logic [N-1:0]    match,
    input  logic [IdxW-1:0] head,
    output logic            found,
    output logic [IdxW-1:0] idx
);

    logic [N-1:0]    rotated;
    logic [IdxW-1:0] offset;

    // N is a power of two, so head + i wraps naturally in IdxW bits.
    always_comb begin
        rotated = '0;
        for (int i = 0; i < N; i++) begin
            rotated[i] = match[head + IdxW'(i)];
        end
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IdxW'(i);
            end
        end
        found = |rotated;
        idx   = head + offset;
    end

endmodule

// File: rtl/time_tmr_retry_start.sv
// rtl/time_tmr_retry_start.sv - ID-tagged buffered issue stage that re-issues faulted items
module time_tmr_retry_start
    import time_tmr_retry_pkg::*;
#(
    parameter type DataType   = logic,
    parameter int  IDSize     = 4,
    parameter int  MaxRetries = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  DataType           data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic [IDSize-1:0] id_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic              done_valid_i,
    input  logic [IDSize-1:0] done_id_i,
    input  logic              done_fault_i,
    output logic              retry_exhausted_o,
    output logic              spurious_done_o
);

    localparam int NumEntries = 2 ** IDSize;
    localparam int CntW       = retry_cnt_width(MaxRetries);

    entry_state_e      st  [NumEntries];
    DataType           dat [NumEntries];
    logic [CntW-1:0]   cnt [NumEntries];

    logic [IDSize-1:0]     head, tail, issue, hold_id, retry_id, id_buf;
    logic                  hold_valid, exh_q, spur_q;
    logic [NumEntries-1:0] retry_vec, free_vec;
    logic                  all_free, full, bypass, retry_found, new_found, valid_buf;
    logic                  accept, hs, done_en;

    oldest_match_pick #(
        .N    (NumEntries),
        .IdxW (IDSize)
    ) u_retry_pick (
        .match (retry_vec),
        .head  (head),
        .found (retry_found),
        .idx   (retry_id)
    );

    // A latched offer wins over everything so data_o/id_o stay stable until taken.
    always_comb begin
        for (int i = 0; i < NumEntries; i++) begin
            retry_vec[i] = (st[i] == RETRY);
            free_vec[i]  = (st[i] == FREE);
        end
        all_free  = &free_vec;
        full      = ~free_vec[tail];
        bypass    = ~enable_i & all_free;
        new_found = (st[issue] == NEW);
        if (hold_valid) begin
            valid_buf = 1'b1;
            id_buf    = hold_id;
        end else if (retry_found) begin
            valid_buf = 1'b1;
            id_buf    = retry_id;
        end else begin
            valid_buf = new_found;
            id_buf    = issue;
        end
    end

    always_comb begin
        valid_o = 1'b0;
        ready_o = 1'b0;
        data_o  = dat[id_buf];
        id_o    = '0;
        if (!rst_i) begin
            if (bypass) begin
                data_o  = data_i;
                valid_o = valid_i;
                ready_o = ready_i;
            end else begin
                valid_o = valid_buf;
                ready_o = enable_i & ~full;
                id_o    = id_buf;
            end
        end
    end

    assign accept            = ~bypass & valid_i & ready_o;
    assign hs                = ~bypass & valid_o & ready_i;
    assign done_en           = ~bypass & done_valid_i;
    assign retry_exhausted_o = exh_q & ~rst_i;
    assign spurious_done_o   = spur_q & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            dat[tail] <= data_i;
        end
    end

    // Accept hits a FREE slot, handshake a NEW/RETRY slot, done only a SENT slot: never the same entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumEntries; i++) begin
                st[i]  <= FREE;
                cnt[i] <= '0;
            end
            head       <= '0;
            tail       <= '0;
            issue      <= '0;
            hold_valid <= 1'b0;
            hold_id    <= '0;
            exh_q      <= 1'b0;
            spur_q     <= 1'b0;
        end else begin
            exh_q      <= 1'b0;
            spur_q     <= 1'b0;
            hold_valid <= ~bypass & valid_buf & ~ready_i;
            hold_id    <= id_buf;
            if (st[head] == FREE && !all_free) begin
                head <= head + 1'b1;
            end
            if (accept) begin
                st[tail]  <= NEW;
                cnt[tail] <= '0;
                tail      <= tail + 1'b1;
            end
            if (hs) begin
                st[id_buf] <= SENT;
                if (st[id_buf] == NEW) begin
                    issue <= issue + 1'b1;
                end
            end
            if (done_en) begin
                if (st[done_id_i] == SENT) begin
                    if (!done_fault_i) begin
                        st[done_id_i]  <= FREE;
                        cnt[done_id_i] <= '0;
                    end else if (cnt[done_id_i] < CntW'(MaxRetries)) begin
                        st[done_id_i]  <= RETRY;
                        cnt[done_id_i] <= cnt[done_id_i] + 1'b1;
                    end else begin
                        st[done_id_i]  <= FREE;
                        cnt[done_id_i] <= '0;
                        exh_q          <= 1'b1;
                    end
                end else begin
                    spur_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_time_tmr_retry_start.sv
// tb/tb_time_tmr_retry_start.sv - directed self-checking bench for time_tmr_retry_start
module tb_time_tmr_retry_start;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic [7:0] data_out;
    logic [3:0] id_out;
    logic       valid_out;
    logic       ready_in;
    logic       done_valid;
    logic [3:0] done_id;
    logic       done_fault;
    logic       exh;
    logic       spur;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] vals [16];
    int         ord  [$] = {0, 1, 2, 3, 4, 3, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    int         frees[$] = {1, 2, 4, 6, 7, 8, 9, 10, 11, 12};
    int         drain[$] = {13, 14, 15, 0};

    time_tmr_retry_start #(
        .DataType   (logic [7:0]),
        .IDSize     (4),
        .MaxRetries (2)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .enable_i          (enable),
        .data_i            (data_in),
        .valid_i           (valid_in),
        .ready_o           (ready_out),
        .data_o            (data_out),
        .id_o              (id_out),
        .valid_o           (valid_out),
        .ready_i           (ready_in),
        .done_valid_i      (done_valid),
        .done_id_i         (done_id),
        .done_fault_i      (done_fault),
        .retry_exhausted_o (exh),
        .spurious_done_o   (spur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic done_set(input logic v, input int id, input logic f);
        done_valid = v;
        done_id    = 4'(id);
        done_fault = f;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) vals[i] = (i == 3) ? 8'hA5 : 8'(8'h20 + i);

        rst = 1'b1; enable = 1'b0; data_in = 8'h00; valid_in = 1'b1; ready_in = 1'b1;
        done_set(1'b0, 0, 1'b0);
        settle();
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_ready", 32'(ready_out), 0);
        at_edge();
        at_edge();
        rst = 1'b0; valid_in = 1'b0;
        settle();
        chk("post_rst_exh", 32'(exh), 0);
        chk("post_rst_spur", 32'(spur), 0);

        for (int k = 0; k < 100; k++) begin
            at_edge();
            data_in  = 8'($urandom);
            valid_in = 1'($urandom_range(0, 1));
            ready_in = 1'b1;
            done_set(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            settle();
            chk("byp_data", 32'(data_out), 32'(data_in));
            chk("byp_valid", 32'(valid_out), 32'(valid_in));
            chk("byp_ready", 32'(ready_out), 32'(ready_in));
            chk("byp_id", 32'(id_out), 0);
            chk("byp_spur", 32'(spur), 0);
            chk("byp_exh", 32'(exh), 0);
        end

        at_edge();
        enable = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
        done_set(1'b0, 0, 1'b0);
        settle();
        chk("en_ready", 32'(ready_out), 1);
        chk("en_valid", 32'(valid_out), 0);
        for (int i = 0; i < 16; i++) begin
            at_edge();
            valid_in = 1'b1; data_in = vals[i];
            settle();
            chk("fill_ready", 32'(ready_out), 1);
            if (i == 0) begin
                chk("fill_first_valid", 32'(valid_out), 0);
            end else begin
                chk("fill_valid", 32'(valid_out), 1);
                chk("fill_hold_id", 32'(id_out), 0);
                chk("fill_hold_data", 32'(data_out), 32'(vals[0]));
            end
        end
        at_edge();
        valid_in = 1'b1; data_in = 8'hFF;
        settle();
        chk("full_ready", 32'(ready_out), 0);

        for (int p = 0; p < 17; p++) begin
            at_edge();
            valid_in = 1'b0; ready_in = 1'b1;
            done_set((p == 4) || (p == 6), 3, (p == 4));
            settle();
            chk("strm_valid", 32'(valid_out), 1);
            chk("strm_id", 32'(id_out), 32'(ord[p]));
            chk("strm_data", 32'(data_out), 32'(vals[ord[p]]));
            chk("strm_ready", 32'(ready_out), 0);
            chk("strm_spur", 32'(spur), 0);
        end

        at_edge(); done_set(1'b1, 5, 1'b1); settle();
        chk("f5_idle0", 32'(valid_out), 0);
        at_edge(); done_set(1'b0, 5, 1'b0); settle();
        chk("f5_re1_valid", 32'(valid_out), 1);
        chk("f5_re1_id", 32'(id_out), 5);
        chk("f5_re1_data", 32'(data_out), 32'h25);
        at_edge(); done_set(1'b1, 5, 1'b1); settle();
        chk("f5_idle1", 32'(valid_out), 0);
        at_edge(); done_set(1'b0, 5, 1'b0); settle();
        chk("f5_re2_id", 32'(id_out), 5);
        chk("f5_re2_valid", 32'(valid_out), 1);
        at_edge(); done_set(1'b1, 5, 1'b1); settle();
        chk("f5_exh_early", 32'(exh), 0);
        at_edge(); done_set(1'b1, 5, 1'b0); settle();
        chk("f5_exh_pulse", 32'(exh), 1);
        chk("f5_dropped_valid", 32'(valid_out), 0);
        at_edge(); done_set(1'b0, 0, 1'b0); settle();
        chk("f5_exh_once", 32'(exh), 0);
        chk("f5_spur_pulse", 32'(spur), 1);
        at_edge(); settle();
        chk("f5_spur_once", 32'(spur), 0);

        at_edge(); ready_in = 1'b0; done_set(1'b1, 0, 1'b0); settle();
        chk("h_full", 32'(ready_out), 0);
        at_edge(); done_set(1'b0, 0, 1'b0); valid_in = 1'b1; data_in = 8'h77; settle();
        chk("h_ready", 32'(ready_out), 1);
        at_edge(); valid_in = 1'b0; done_set(1'b1, 2, 1'b1); settle();
        chk("h_offer_id", 32'(id_out), 0);
        chk("h_offer_data", 32'(data_out), 32'h77);
        at_edge(); done_set(1'b0, 0, 1'b0); settle();
        chk("h_stable_valid", 32'(valid_out), 1);
        chk("h_stable_id", 32'(id_out), 0);
        chk("h_stable_data", 32'(data_out), 32'h77);
        at_edge(); ready_in = 1'b1; settle();
        chk("h_take_id", 32'(id_out), 0);
        at_edge(); settle();
        chk("h_retry_id", 32'(id_out), 2);
        chk("h_retry_data", 32'(data_out), 32'h22);
        at_edge(); settle();
        chk("h_idle", 32'(valid_out), 0);

        foreach (frees[i]) begin
            at_edge(); done_set(1'b1, frees[i], 1'b0); settle();
            chk("free_spur", 32'(spur), 0);
        end
        foreach (drain[i]) begin
            at_edge();
            enable = 1'b0; valid_in = 1'b1; data_in = 8'h99; ready_in = 1'b1;
            done_set(1'b1, drain[i], 1'b0);
            settle();
            chk("drain_ready", 32'(ready_out), 0);
            chk("drain_valid", 32'(valid_out), 0);
        end
        at_edge(); done_set(1'b0, 0, 1'b0); settle();
        chk("drained_byp_ready", 32'(ready_out), 1);
        chk("drained_byp_valid", 32'(valid_out), 1);
        chk("drained_byp_data", 32'(data_out), 32'h99);
        chk("drained_spur", 32'(spur), 0);

        at_edge();
        enable = 1'b1; valid_in = 1'b1; data_in = 8'h31; ready_in = 1'b0;
        done_set(1'b1, 9, 1'b0);
        settle();
        chk("rs_ready", 32'(ready_out), 1);
        chk("rs_valid0", 32'(valid_out), 0);
        at_edge(); data_in = 8'h32; settle();
        chk("rs_valid1", 32'(valid_out), 1);
        chk("rs_id", 32'(id_out), 1);
        chk("rs_data", 32'(data_out), 32'h31);
        chk("rs_spur", 32'(spur), 1);
        at_edge(); rst = 1'b1; data_in = 8'h33; done_set(1'b0, 0, 1'b0); settle();
        chk("rs_in_rst_valid", 32'(valid_out), 0);
        chk("rs_in_rst_ready", 32'(ready_out), 0);
        chk("rs_in_rst_spur", 32'(spur), 0);
        at_edge(); rst = 1'b0; enable = 1'b0; valid_in = 1'b0; ready_in = 1'b1; settle();
        chk("rs_after_valid", 32'(valid_out), 0);
        chk("rs_after_empty", 32'(ready_out), 1);
        chk("rs_after_spur", 32'(spur), 0);
        chk("rs_after_exh", 32'(exh), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
